muldiv_execute: RTL
===================

Name: muldiv_execute

Overview:
- Parametrised multi-cycle execute unit for the RV32M multiply/divide group. It runs beside the single-cycle ALU in the execute stage.
- Accepts one operation at a time, iterates one bit per cycle, and holds the result until downstream accepts it.
- Drives a stall request so the pipeline freezes while it iterates. Flush aborts the operation in flight.

Parameters:
- XLEN, 32, operand and result width; must be ≥8 and a power of two.
- FAST_MUL, 0, 1 = multiply done in one cycle (registered single-cycle product); 0 = iterative shift-add multiply.

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- requestValid  in  1  operation offered this cycle
- requestOp  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- operandA  in  XLEN  rs1 value
- operandB  in  XLEN  rs2 value
- destinationRegister  in  5  rd tag, carried to the result
- flush  in  1  abort in-flight or pending operation
- downstreamStall  in  1  memory stage cannot accept the result
- requestReady  out  1  unit idle; request accepted on this edge if requestValid
- busy  out  1  stall request to the hazard unit
- resultValid  out  1  resultData is valid
- resultData  out  XLEN  operation result
- resultDestination  out  5  rd tag of the result

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - resultValid, busy, resultData and resultDestination = 0.
  - requestReady = 0 while reset is high, and 1 on the first cycle after reset.
- States: IDLE, ITER, DONE.
- IDLE:
  - requestReady = 1.
  - On requestValid && !flush, latch op, operand magnitudes, sign flags and rd tag.
  - Go to DONE on the next edge for any short-path case, otherwise go to ITER with counter = XLEN-1.
- Short-path (1-cycle) cases:
  - Any multiply when FAST_MUL = 1.
  - Divide/remainder with operandB = 0.
  - Signed overflow: DIV/REM with operandA = 1<<(XLEN-1) and operandB = all-ones.
- ITER:
  - busy = 1.
  - One partial-product add (multiply) or one restoring-divide subtract step (divide) per cycle.
  - Counter decrements each cycle. At counter = 0, apply sign fix-up and go to DONE.
- Latency:
  - Accept edge to resultValid high = XLEN+1 cycles on the iterative path (33 for XLEN = 32).
  - 1 cycle on the short path.
- DONE:
  - resultValid = 1; resultData and resultDestination are stable.
  - Stay in DONE while downstreamStall = 1.
  - Go to IDLE on the first edge with downstreamStall = 0.
  - busy = downstreamStall in DONE.
  - No new request is accepted in DONE.
- Arithmetic:
  - Operands are converted to magnitudes; the core works unsigned on 2·XLEN bits for multiply.
  - MUL returns the low XLEN bits. MULH is signed×signed, MULHSU is signed A × unsigned B, MULHU is unsigned×unsigned; these three return the high XLEN bits.
  - DIV/DIVU round toward zero.
  - REM/REMU remainder takes the sign of the dividend.
  - Sign fix-up is a two's-complement negate applied in the final ITER cycle.
- Divide by zero: quotient = all-ones (DIV and DIVU); remainder = operandA.
- Signed overflow: quotient = operandA; remainder = 0.
- Flush:
  - Highest priority below reset, in any state.
  - Next edge: state = IDLE, resultValid = 0, busy = 0.
  - A request presented in the same cycle as flush is ignored.
  - resultData is not cleared on flush.
- Reset mid-operation: same as flush, plus data/tag registers cleared to 0.
- requestValid outside IDLE is ignored; the upstream stage must hold the request, which busy guarantees.

Test Plan:
- XLEN=32, FAST_MUL=0: MUL 7 × 0xFFFFFFFD → resultData 0xFFFFFFEB, resultValid exactly 33 cycles after accept, busy high for those 32 ITER cycles.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2; rd tag 5'd17 echoed on resultDestination.
- DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0. Each with resultValid 1 cycle after accept.
- Flush asserted on the 10th ITER cycle of DIVU → IDLE next edge, resultValid never rises, requestReady = 1; the next request completes normally.
- downstreamStall high for 4 cycles in DONE → resultValid/resultData held constant, IDLE on the first low cycle. Repeat with FAST_MUL=1: MUL 3×4 → 12 after 1 cycle.

Source files
------------

// File: rtl/muldiv_execute.sv
// RV32M multiply/divide execute unit: one bit per cycle shift-add multiply and
// restoring divide, with one-cycle paths for fast multiply and divide corner cases.
module muldiv_execute #(
    parameter int unsigned XLEN     = 32,
    parameter bit          FAST_MUL = 1'b0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            requestValid,
    input  logic [2:0]      requestOp,
    input  logic [XLEN-1:0] operandA,
    input  logic [XLEN-1:0] operandB,
    input  logic [4:0]      destinationRegister,
    input  logic            flush,
    input  logic            downstreamStall,
    output logic            requestReady,
    output logic            busy,
    output logic            resultValid,
    output logic [XLEN-1:0] resultData,
    output logic [4:0]      resultDestination
);
    localparam int unsigned   CW      = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] mag_q, mag_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] data_d;
    logic [4:0]      dest_d;

    // Operand decode: signedness per funct3 and magnitudes
    logic            signed_a, signed_b, sign_a, sign_b, is_rem;
    logic [XLEN-1:0] mag_a, mag_b;

    assign signed_a = !(requestOp[0] && (requestOp[1] || requestOp[2]));
    assign signed_b = signed_a && (requestOp != 3'd2);
    assign sign_a   = signed_a && operandA[XLEN-1];
    assign sign_b   = signed_b && operandB[XLEN-1];
    assign is_rem   = requestOp[2] && requestOp[1];
    assign mag_a    = sign_a ? -operandA : operandA;
    assign mag_b    = sign_b ? -operandB : operandB;

    logic [2*XLEN-1:0] fast_p, fast_fix;
    assign fast_p   = {XLEN'(0), mag_a} * {XLEN'(0), mag_b};
    assign fast_fix = (sign_a ^ sign_b) ? -fast_p : fast_p;

    // One iteration: hi/lo hold {accumulator, multiplier} or {remainder, quotient}
    logic [XLEN:0]     mul_sum, div_shift;
    logic [XLEN-1:0]   div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] step_p, fix_p;
    logic [XLEN-1:0]   fix_q, fix_r, final_res;

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : (XLEN+1)'(0));
    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_ge    = div_shift >= {1'b0, mag_q};
    assign div_diff  = div_shift[XLEN-1:0] - mag_q;
    assign step_p    = op_q[2]
                     ? {(div_ge ? div_diff : div_shift[XLEN-1:0]), lo_q[XLEN-2:0], div_ge}
                     : {mul_sum, lo_q[XLEN-1:1]};
    assign fix_p     = neg_q ? -step_p : step_p;
    assign fix_q     = neg_q ? -step_p[XLEN-1:0] : step_p[XLEN-1:0];
    assign fix_r     = neg_q ? -step_p[2*XLEN-1:XLEN] : step_p[2*XLEN-1:XLEN];
    assign final_res = !op_q[2] ? ((op_q[1:0] == 2'd0) ? fix_p[XLEN-1:0] : fix_p[2*XLEN-1:XLEN])
                                : (op_q[1] ? fix_r : fix_q);

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        neg_d   = neg_q;
        mag_d   = mag_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        data_d  = resultData;
        dest_d  = resultDestination;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (requestValid) begin
                        op_d    = requestOp;
                        neg_d   = is_rem ? sign_a : (sign_a ^ sign_b);
                        dest_d  = destinationRegister;
                        count_d = CW'(XLEN-1);
                        hi_d    = '0;
                        lo_d    = requestOp[2] ? mag_a : mag_b;
                        mag_d   = requestOp[2] ? mag_b : mag_a;
                        state_d = ITER;
                        if (!requestOp[2] && FAST_MUL) begin
                            data_d  = (requestOp[1:0] == 2'd0) ? fast_fix[XLEN-1:0]
                                                               : fast_fix[2*XLEN-1:XLEN];
                            state_d = DONE;
                        end else if (requestOp[2] && operandB == '0) begin
                            data_d  = requestOp[1] ? operandA : '1;
                            state_d = DONE;
                        end else if (requestOp[2] && !requestOp[0] &&
                                     operandA == MIN_INT && operandB == '1) begin
                            data_d  = requestOp[1] ? '0 : operandA;
                            state_d = DONE;
                        end
                    end
                end
                ITER: begin
                    hi_d    = step_p[2*XLEN-1:XLEN];
                    lo_d    = step_p[XLEN-1:0];
                    count_d = count_q - CW'(1);
                    if (count_q == '0) begin
                        data_d  = final_res;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (!downstreamStall) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q           <= IDLE;
            count_q           <= '0;
            op_q              <= '0;
            neg_q             <= 1'b0;
            mag_q             <= '0;
            hi_q              <= '0;
            lo_q              <= '0;
            resultData        <= '0;
            resultDestination <= '0;
        end else begin
            state_q           <= state_d;
            count_q           <= count_d;
            op_q              <= op_d;
            neg_q             <= neg_d;
            mag_q             <= mag_d;
            hi_q              <= hi_d;
            lo_q              <= lo_d;
            resultData        <= data_d;
            resultDestination <= dest_d;
        end
    end

    assign requestReady = (state_q == IDLE) && !reset;
    assign busy         = (state_q == ITER) || ((state_q == DONE) && downstreamStall);
    assign resultValid  = (state_q == DONE);
endmodule
